rv_multicycle_core: RTL

- Multi-cycle successor to the single-cycle RV64I datapath: one shared ALU, register file and immediate path, sequenced by an FSM.
- Fetches and loads/stores through a single request/ready memory port, so instruction and data memories can have wait states.
- Parametrised in XLEN and reset PC; supports add, sub, and, or, addi, ld, sd, beq and ecall (halt).

---
 rtl/rv_pkg.sv | 54 +++++
 rtl/rv_multicycle_core_if.sv | 27 ++
 rtl/rv_regfile.sv | 32 +++
 rtl/rv_multicycle_core.sv | 183 ++++++++++++++++++
 4 files changed

// File: rtl/rv_pkg.sv
`default_nettype none
// ============================================================================
// Module      : rv_pkg
// Description : Shared opcodes, ALU encodings and FSM states for rv_multicycle_core.
// Revision    : 1.0
// ============================================================================
package rv_pkg;

    localparam logic [6:0] c_OP_R    = 7'b0110011;
    localparam logic [6:0] c_OP_IALU = 7'b0010011;
    localparam logic [6:0] c_OP_LD   = 7'b0000011;
    localparam logic [6:0] c_OP_SD   = 7'b0100011;
    localparam logic [6:0] c_OP_BEQ  = 7'b1100011;
    localparam logic [6:0] c_OP_SYS  = 7'b1110011;

    // Same operation codes as the ALU_64_Bit block of the single-cycle core
    localparam logic [3:0] c_ALU_AND = 4'b0000;
    localparam logic [3:0] c_ALU_OR  = 4'b0001;
    localparam logic [3:0] c_ALU_ADD = 4'b0010;
    localparam logic [3:0] c_ALU_SUB = 4'b0110;

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4,
        S_HALT   = 3'd5
    } state_t;

    function automatic logic [3:0] alu_ctrl(input logic [6:0] opcode,
                                            input logic       funct7_b5,
                                            input logic [2:0] funct3);
        logic [3:0] op;
        op = c_ALU_ADD;
        if (opcode == c_OP_R) begin
            case ({funct7_b5, funct3})
                4'b1000: op = c_ALU_SUB;
                4'b0111: op = c_ALU_AND;
                4'b0110: op = c_ALU_OR;
                default: op = c_ALU_ADD;
            endcase
        end else if (opcode == c_OP_BEQ) begin
            op = c_ALU_SUB;
        end
        return op;
    endfunction

    function automatic logic is_known_op(input logic [6:0] opcode);
        return opcode inside {c_OP_R, c_OP_IALU, c_OP_LD, c_OP_SD, c_OP_BEQ, c_OP_SYS};
    endfunction

endpackage
`default_nettype wire

// File: rtl/rv_multicycle_core_if.sv
`default_nettype none
// ============================================================================
// Module      : rv_multicycle_core_if
// Description : Shared instruction/data request-ready memory port.
// Revision    : 1.0
// ============================================================================
interface rv_multicycle_core_if #(
    parameter int XLEN = 64
);
    logic            mem_req;
    logic            mem_we;
    logic [XLEN-1:0] mem_addr;
    logic [XLEN-1:0] mem_wdata;
    logic [XLEN-1:0] mem_rdata;
    logic            mem_ready;

    modport master (
        output mem_req, mem_we, mem_addr, mem_wdata,
        input  mem_rdata, mem_ready
    );

    modport slave (
        input  mem_req, mem_we, mem_addr, mem_wdata,
        output mem_rdata, mem_ready
    );
endinterface
`default_nettype wire

// File: rtl/rv_regfile.sv
`default_nettype none
// ============================================================================
// Module      : rv_regfile
// Description : Two async read ports, one sync write port; x0 reads as zero.
// Revision    : 1.0
// ============================================================================
module rv_regfile #(
    parameter int XLEN = 64,
    parameter int NREG = 32,
    parameter int AW   = $clog2(NREG)
) (
    input  logic            clk,
    input  logic            i_we,
    input  logic [AW-1:0]   i_waddr,
    input  logic [XLEN-1:0] i_wdata,
    input  logic [AW-1:0]   i_raddr1,
    input  logic [AW-1:0]   i_raddr2,
    output logic [XLEN-1:0] o_rdata1,
    output logic [XLEN-1:0] o_rdata2
);
    logic [XLEN-1:0] r_regs [NREG];

    always_ff @(posedge clk) begin
        if (i_we && (i_waddr != '0)) begin
            r_regs[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata1 = (i_raddr1 == '0) ? '0 : r_regs[i_raddr1];
    assign o_rdata2 = (i_raddr2 == '0) ? '0 : r_regs[i_raddr2];
endmodule
`default_nettype wire

// File: rtl/rv_multicycle_core.sv
`default_nettype none
// ============================================================================
// Module      : rv_multicycle_core
// Description : Multi-cycle RV64I subset core on one request/ready memory port.
//               RV_ILLEGAL_HALT_EN: unknown opcodes halt instead of acting as NOP.
// Revision    : 1.0
// ============================================================================
module rv_multicycle_core
    import rv_pkg::*;
#(
    parameter int              XLEN     = 64,
    parameter logic [XLEN-1:0] RESET_PC = '0,
    parameter int              NREG     = 32
) (
    input  logic                 clk,
    input  logic                 reset,
    rv_multicycle_core_if.master mem,
    output logic                 retire,
    output logic [XLEN-1:0]      pc_out,
    output logic                 halt
);
    localparam int              c_REG_AW  = $clog2(NREG);
    localparam logic [XLEN-1:0] c_PC_STEP = XLEN'(4);

    state_t r_state, w_state_next;

    logic [31:0]     r_ir;
    logic [XLEN-1:0] r_pc, r_a, r_b, r_imm, r_alu_out, r_mdr, r_target;
    logic [XLEN-1:0] r_mem_addr, r_mem_wdata;
    logic            r_taken, r_mem_req, r_mem_we, r_retire, r_halt;

    logic [6:0]          w_opcode;
    logic [c_REG_AW-1:0] w_rs1, w_rs2, w_rd;
    logic [XLEN-1:0]     w_rs1_data, w_rs2_data, w_imm, w_alu_b, w_alu_result, w_pc_next;
    logic [3:0]          w_alu_op;
    logic                w_is_mem, w_rf_we;

    assign w_opcode = r_ir[6:0];
    assign w_rd     = r_ir[7  +: c_REG_AW];
    assign w_rs1    = r_ir[15 +: c_REG_AW];
    assign w_rs2    = r_ir[20 +: c_REG_AW];
    assign w_is_mem = (w_opcode == c_OP_LD) || (w_opcode == c_OP_SD);
    assign w_alu_op = alu_ctrl(w_opcode, r_ir[30], r_ir[14:12]);

    // SB immediate is kept in half-word units; EXEC shifts it into a byte offset
    always_comb begin
        w_imm = {{(XLEN-12){r_ir[31]}}, r_ir[31:20]};
        if (w_opcode == c_OP_SD) begin
            w_imm = {{(XLEN-12){r_ir[31]}}, r_ir[31:25], r_ir[11:7]};
        end else if (w_opcode == c_OP_BEQ) begin
            w_imm = {{(XLEN-12){r_ir[31]}}, r_ir[31], r_ir[7], r_ir[30:25], r_ir[11:8]};
        end
    end

    assign w_alu_b = ((w_opcode == c_OP_R) || (w_opcode == c_OP_BEQ)) ? r_b : r_imm;

    always_comb begin
        w_alu_result = r_a + w_alu_b;
        case (w_alu_op)
            c_ALU_AND: w_alu_result = r_a & w_alu_b;
            c_ALU_OR:  w_alu_result = r_a | w_alu_b;
            c_ALU_SUB: w_alu_result = r_a - w_alu_b;
            default:   w_alu_result = r_a + w_alu_b;
        endcase
    end

    assign w_rf_we   = (r_state == S_WB) &&
                       ((w_opcode == c_OP_R) || (w_opcode == c_OP_IALU) || (w_opcode == c_OP_LD));
    assign w_pc_next = r_taken ? r_target : (r_pc + c_PC_STEP);

    rv_regfile #(
        .XLEN (XLEN),
        .NREG (NREG),
        .AW   (c_REG_AW)
    ) u_regfile (
        .clk      (clk),
        .i_we     (w_rf_we),
        .i_waddr  (w_rd),
        .i_wdata  ((w_opcode == c_OP_LD) ? r_mdr : r_alu_out),
        .i_raddr1 (w_rs1),
        .i_raddr2 (w_rs2),
        .o_rdata1 (w_rs1_data),
        .o_rdata2 (w_rs2_data)
    );

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state <= S_FETCH;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_FETCH:  if (r_mem_req && mem.mem_ready) w_state_next = S_DECODE;
            S_DECODE: begin
                w_state_next = S_EXEC;
                if (w_opcode == c_OP_SYS) w_state_next = S_HALT;
`ifdef RV_ILLEGAL_HALT_EN
                if (!is_known_op(w_opcode)) w_state_next = S_HALT;
`endif
            end
            S_EXEC:   w_state_next = w_is_mem ? S_MEM : S_WB;
            S_MEM:    if (mem.mem_ready) w_state_next = S_WB;
            S_WB:     w_state_next = S_FETCH;
            S_HALT:   w_state_next = S_HALT;
            default:  w_state_next = S_FETCH;
        endcase
    end

    // Request outputs are registered and set on the edge that enters FETCH/MEM
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_pc        <= RESET_PC;
            r_mem_req   <= 1'b0;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
            r_retire    <= 1'b0;
            r_halt      <= 1'b0;
            r_taken     <= 1'b0;
        end else begin
            r_retire <= (w_state_next == S_WB);
            r_halt   <= r_halt | (w_state_next == S_HALT);
            case (r_state)
                S_FETCH: begin
                    if (!r_mem_req) begin
                        r_mem_req  <= 1'b1;
                        r_mem_we   <= 1'b0;
                        r_mem_addr <= r_pc;
                    end else if (mem.mem_ready) begin
                        r_ir      <= mem.mem_rdata[31:0];
                        r_mem_req <= 1'b0;
                    end
                end
                S_DECODE: begin
                    r_a     <= w_rs1_data;
                    r_b     <= w_rs2_data;
                    r_imm   <= w_imm;
                    r_taken <= 1'b0;
                end
                S_EXEC: begin
                    r_alu_out <= w_alu_result;
                    if (w_opcode == c_OP_BEQ) begin
                        r_taken  <= (w_alu_result == '0);
                        r_target <= r_pc + (r_imm << 1);
                    end
                    if (w_is_mem) begin
                        r_mem_req   <= 1'b1;
                        r_mem_we    <= (w_opcode == c_OP_SD);
                        r_mem_addr  <= w_alu_result;
                        r_mem_wdata <= r_b;
                    end
                end
                S_MEM: begin
                    if (mem.mem_ready) begin
                        r_mdr     <= mem.mem_rdata;
                        r_mem_req <= 1'b0;
                        r_mem_we  <= 1'b0;
                    end
                end
                S_WB: begin
                    r_pc       <= w_pc_next;
                    r_mem_req  <= 1'b1;
                    r_mem_we   <= 1'b0;
                    r_mem_addr <= w_pc_next;
                end
                default: ;
            endcase
        end
    end

    assign mem.mem_req   = r_mem_req;
    assign mem.mem_we    = r_mem_we;
    assign mem.mem_addr  = r_mem_addr;
    assign mem.mem_wdata = r_mem_wdata;
    assign retire        = r_retire;
    assign pc_out        = r_pc;
    assign halt          = r_halt;
endmodule
`default_nettype wire
